// File: rtl/nn_pkg.sv
// Shared types and handshake helper for the classifier back end.
package nn_pkg;

  typedef enum logic {ACCUM = 1'b0, OUTPUT = 1'b1} argmax_state_t;

  function automatic logic fire(input logic v, input logic r);
    return v & r;
  endfunction

endpackage

// File: rtl/nn_argmax_stage.sv
// Serial argmax over M signed words per frame; emits {index, value} of the
// largest word as one valid/ready beat, then counts the handoff.
module nn_argmax_stage
  import nn_pkg::*;
#(
  parameter  int M    = 8,
  parameter  int T    = 12,
  parameter  int FCW  = 16,
  localparam int IDXW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic signed [T-1:0]  data_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [IDXW-1:0]      class_idx,
  output logic signed [T-1:0]  class_val,
  output logic [FCW-1:0]       frame_cnt
);

  argmax_state_t       state_q, state_d;
  logic [IDXW-1:0]     cnt_q, idx_q, nxt_idx;
  logic signed [T-1:0] max_q, nxt_max;
  logic                in_fire, out_fire, last_beat;

  assign s_ready   = (state_q == ACCUM) & ~reset;
  assign m_valid   = (state_q == OUTPUT);
  assign in_fire   = fire(s_valid, s_ready);
  assign out_fire  = fire(m_valid, m_ready);
  assign last_beat = (cnt_q == IDXW'(M - 1));

  // Strict compare keeps the earliest index on ties; word 0 always seeds.
  always_comb begin
    nxt_max = max_q;
    nxt_idx = idx_q;
    if (cnt_q == '0) begin
      nxt_max = data_in;
      nxt_idx = '0;
    end else if (data_in > max_q) begin
      nxt_max = data_in;
      nxt_idx = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ACCUM) begin
      if (in_fire && last_beat) state_d = OUTPUT;
    end else begin
      if (out_fire) state_d = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      class_idx <= '0;
      class_val <= '0;
      frame_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        max_q <= nxt_max;
        idx_q <= nxt_idx;
        if (last_beat) begin
          cnt_q     <= '0;
          class_idx <= nxt_idx;
          class_val <= nxt_max;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (out_fire) frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_nn_argmax_stage.sv
// Self-checking bench for nn_argmax_stage: table vectors, stall/reset
// sequences and randomized frames against an array-scan argmax model.
module tb_nn_argmax_stage;

  localparam int M = 8;
  localparam int T = 12;
  localparam int FCW = 16;

  typedef logic signed [T-1:0] frame_t [M];
  typedef struct {
    frame_t w;
    int     idx;
    int     val;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic [2:0]          class_idx;
  logic signed [T-1:0] class_val;
  logic [FCW-1:0]      frame_cnt;

  int checks = 0;
  int errors = 0;
  int handoffs = 0;
  int exp_idx_q[$];
  int exp_val_q[$];

  nn_argmax_stage #(.M(M), .T(T), .FCW(FCW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .data_in(data_in), .m_valid(m_valid), .m_ready(m_ready),
    .class_idx(class_idx), .class_val(class_val), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: first index holding the largest signed value.
  function automatic void ref_argmax(input frame_t f, output int idx, output int val);
    idx = 0;
    for (int i = 1; i < M; i++)
      if (f[i] > f[idx]) idx = i;
    val = int'(f[idx]);
  endfunction

  // Result monitor: handoff happens on the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      handoffs = 0;
      exp_idx_q.delete();
      exp_val_q.delete();
    end else if (m_valid && m_ready) begin
      handoffs++;
      if (exp_idx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got idx %0d val %0d expected none", class_idx, class_val);
      end else begin
        chk("mon_idx", int'(class_idx), exp_idx_q.pop_front());
        chk("mon_val", int'(class_val), exp_val_q.pop_front());
      end
    end
  end

  // Drives one frame; returns #1 after the edge that accepted the last word.
  task automatic send_frame(input frame_t f, input int bubble_pct);
    int ei, ev, guard;
    bit acc;
    for (int i = 0; i < M; i++) begin
      guard = 0;
      do begin
        s_valid = ($urandom_range(99) >= bubble_pct);
        data_in = s_valid ? f[i] : T'($urandom_range(0, 4095));
        acc = s_valid && s_ready;
        step();
        guard++;
      end while (!acc && guard < 200);
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: word %0d not accepted, s_ready %0d expected 1", i, s_ready);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    ref_argmax(f, ei, ev);
    exp_idx_q.push_back(ei);
    exp_val_q.push_back(ev);
  endtask

  vec_t   tbl [4];
  frame_t f;
  int     sidx, sval;

  initial begin
    tbl[0].w = '{12'sd3, -12'sd7, 12'sd20, 12'sd5, 12'sd0, 12'sd19, 12'sd2, 12'sd1};
    tbl[0].idx = 2; tbl[0].val = 20;
    tbl[1].w = '{-12'sd5, -12'sd5, -12'sd5, -12'sd5, -12'sd5, -12'sd5, -12'sd1, -12'sd5};
    tbl[1].idx = 6; tbl[1].val = -1;
    tbl[2].w = '{12'sd9, 12'sd9, 12'sd9, 12'sd9, 12'sd9, 12'sd9, 12'sd9, 12'sd9};
    tbl[2].idx = 0; tbl[2].val = 9;
    tbl[3].w = '{-12'sd2048, -12'sd2048, -12'sd2048, -12'sd2048,
                 -12'sd2048, -12'sd2048, -12'sd2048, 12'sd2047};
    tbl[3].idx = 7; tbl[3].val = 2047;

    reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1; data_in = '0;
    step(); step();
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_idx", int'(class_idx), 0);
    chk("rst_val", int'(class_val), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_s_ready", int'(s_ready), 1);

    for (int t = 0; t < 4; t++) begin
      send_frame(tbl[t].w, 0);
      chk("tbl_latency_m_valid", int'(m_valid), 1);
      chk("tbl_s_ready_low", int'(s_ready), 0);
      chk("tbl_idx", int'(class_idx), tbl[t].idx);
      chk("tbl_val", int'(class_val), tbl[t].val);
      step();
      chk("tbl_m_valid_drop", int'(m_valid), 0);
      chk("tbl_frame_cnt", int'(frame_cnt), t + 1);
    end

    // Downstream stall with upstream pushing a would-be winner.
    m_ready = 1'b0;
    f = '{12'sd10, -12'sd3, 12'sd7, 12'sd10, 12'sd0, 12'sd1, 12'sd2, 12'sd3};
    send_frame(f, 0);
    sidx = int'(class_idx); sval = int'(class_val);
    chk("stall_idx", sidx, 0);
    chk("stall_val", sval, 10);
    s_valid = 1'b1; data_in = 12'sd2000;
    repeat (10) begin
      step();
      chk("stall_s_ready", int'(s_ready), 0);
      chk("stall_m_valid", int'(m_valid), 1);
      chk("stall_idx_hold", int'(class_idx), sidx);
      chk("stall_val_hold", int'(class_val), sval);
    end
    m_ready = 1'b1;
    step();
    chk("handoff_s_ready", int'(s_ready), 1);
    chk("handoff_m_valid", int'(m_valid), 0);
    chk("handoff_frame_cnt", int'(frame_cnt), 5);
    s_valid = 1'b0;
    f = '{12'sd1, 12'sd2, 12'sd3, 12'sd50, 12'sd4, 12'sd5, 12'sd6, 12'sd7};
    send_frame(f, 0);
    chk("after_stall_idx", int'(class_idx), 3);
    chk("after_stall_val", int'(class_val), 50);
    step();

    // Randomized frames with input bubbles.
    reset = 1'b1; step(); reset = 1'b0;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < M; i++)
        f[i] = (n % 3 == 0) ? T'($urandom_range(0, 8) - 4) : T'($urandom_range(0, 4095));
      send_frame(f, 50);
    end
    step(); step();
    chk("rand_frame_cnt", int'(frame_cnt), 100);
    chk("rand_handoffs", handoffs, 100);
    chk("rand_queue_empty", exp_idx_q.size(), 0);

    // Reset while a result is pending.
    m_ready = 1'b0;
    f = '{12'sd4, 12'sd3, 12'sd2, 12'sd1, 12'sd0, -12'sd1, -12'sd2, -12'sd3};
    send_frame(f, 0);
    chk("pend_m_valid", int'(m_valid), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("pend_rst_m_valid", int'(m_valid), 0);
    chk("pend_rst_frame_cnt", int'(frame_cnt), 0);
    m_ready = 1'b1;

    // Reset after four accepted words of a frame.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; data_in = T'(100 + i);
      step();
    end
    s_valid = 1'b1; reset = 1'b1;
    #1;
    chk("midrst_s_ready", int'(s_ready), 0);
    step();
    reset = 1'b0; s_valid = 1'b0;
    #1;
    chk("midrst_m_valid", int'(m_valid), 0);
    f = '{12'sd1, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd8};
    send_frame(f, 0);
    chk("midrst_idx", int'(class_idx), 7);
    chk("midrst_val", int'(class_val), 8);
    step();
    chk("midrst_frame_cnt", int'(frame_cnt), 1);
    chk("midrst_handoffs", handoffs, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
